// File: rtl/decode_control_unit.sv
// Instruction decoder producing the registered execute-stage control bundle.
// Optional read-after-write interlock enabled by defining DECODE_HAZARD_EN.
module decode_control_unit #(
    parameter int IW = 16
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [IW-1:0] INSTR_IN,
    input  logic          INSTR_VALID_IN,
    output logic          INSTR_READY_OUT,
    input  logic          STALL_IN,
    output logic          VALID_OUT,
    output logic          AR_OUT,
    output logic          BR_OUT,
    output logic [3:0]    ALU_OUT,
    output logic [1:0]    INPUT_SEL_OUT,
    output logic [5:0]    IMM_OUT,
    output logic          WREN_OUT,
    output logic [2:0]    WRITE_AD_OUT,
    output logic          ADR_MUX_OUT,
    output logic          WRITE_OUT,
    output logic          PC_LOAD_OUT,
    output logic          ILLEGAL_OUT
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_MEM2,
        ST_FLUSH,
        ST_HAZ
    } state_t;

    typedef struct packed {
        logic       valid;
        logic       ar;
        logic       br;
        logic [3:0] alu;
        logic [1:0] sel;
        logic [5:0] imm;
        logic       wren;
        logic [2:0] wad;
        logic       adr_mux;
        logic       write;
        logic       pc_load;
        logic       illegal;
    } ctrl_t;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDI = 4'h8;
    localparam logic [3:0] OP_LD  = 4'h9;
    localparam logic [3:0] OP_ST  = 4'hA;
    localparam logic [3:0] OP_JMP = 4'hB;

    state_t        state_q, state_d;
    ctrl_t         ctrl_q, ctrl_d;
    logic [IW-1:0] instr_q, instr_d;
    logic          accept;
    logic          raw_hazard;

    // First (or only) control word of an instruction.
    function automatic ctrl_t decode_first(input logic [15:0] ins);
        ctrl_t c;
        c = '0;
        c.valid = 1'b1;
        case (ins[15:12])
            OP_NOP: ;
            4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
                c.ar   = 1'b1;
                c.br   = 1'b1;
                c.alu  = ins[15:12];
                c.wren = 1'b1;
                c.wad  = ins[11:9];
            end
            OP_LDI: begin
                c.sel  = 2'd1;
                c.imm  = ins[5:0];
                c.wren = 1'b1;
                c.wad  = ins[11:9];
            end
            OP_LD: begin
                c.ar      = 1'b1;
                c.adr_mux = 1'b1;
            end
            OP_ST: begin
                c.ar      = 1'b1;
                c.br      = 1'b1;
                c.adr_mux = 1'b1;
            end
            OP_JMP: begin
                c.pc_load = 1'b1;
                c.imm     = ins[5:0];
            end
            default: c.illegal = 1'b1;
        endcase
        return c;
    endfunction

    // Second word of a two-cycle memory instruction.
    function automatic ctrl_t decode_second(input logic [15:0] ins);
        ctrl_t c;
        c = '0;
        case (ins[15:12])
            OP_LD: begin
                c.valid = 1'b1;
                c.sel   = 2'd2;
                c.wren  = 1'b1;
                c.wad   = ins[11:9];
            end
            OP_ST: begin
                c.valid = 1'b1;
                c.write = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic state_t follow_state(input logic [3:0] op);
        state_t s;
        case (op)
            OP_LD, OP_ST: s = ST_MEM2;
            OP_JMP:       s = ST_FLUSH;
            default:      s = ST_RUN;
        endcase
        return s;
    endfunction

`ifdef DECODE_HAZARD_EN
    // ctrl_q is the last issued word; bubbles carry wren=0 and so clear tracking.
    logic [3:0] in_op;
    logic       uses_rd;
    logic       uses_rs;

    always_comb begin
        in_op   = INSTR_IN[15:12];
        uses_rd = ((in_op >= 4'h1) && (in_op <= 4'h7)) || (in_op == OP_ST);
        uses_rs = ((in_op >= 4'h1) && (in_op <= 4'h7)) || (in_op == OP_LD) || (in_op == OP_ST);
        raw_hazard = ctrl_q.wren &&
                     ((uses_rd && (ctrl_q.wad == INSTR_IN[11:9])) ||
                      (uses_rs && (ctrl_q.wad == INSTR_IN[8:6])));
    end
`else
    assign raw_hazard = 1'b0;
`endif

    assign INSTR_READY_OUT = (state_q == ST_RUN) && !STALL_IN;
    assign accept          = INSTR_VALID_IN && INSTR_READY_OUT;

    always_comb begin
        state_d = state_q;
        ctrl_d  = ctrl_q;
        instr_d = instr_q;
        if (!STALL_IN) begin
            ctrl_d = '0;
            case (state_q)
                ST_RUN: begin
                    if (accept) begin
                        instr_d = INSTR_IN;
                        if (raw_hazard) begin
                            state_d = ST_HAZ;
                        end else begin
                            ctrl_d  = decode_first(INSTR_IN);
                            state_d = follow_state(INSTR_IN[15:12]);
                        end
                    end
                end
                ST_MEM2: begin
                    ctrl_d  = decode_second(instr_q);
                    state_d = ST_RUN;
                end
                ST_FLUSH: state_d = ST_RUN;
                ST_HAZ: begin
                    ctrl_d  = decode_first(instr_q);
                    state_d = follow_state(instr_q[15:12]);
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_RUN;
            ctrl_q  <= '0;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            instr_q <= instr_d;
        end
    end

    assign VALID_OUT     = ctrl_q.valid;
    assign AR_OUT        = ctrl_q.ar;
    assign BR_OUT        = ctrl_q.br;
    assign ALU_OUT       = ctrl_q.alu;
    assign INPUT_SEL_OUT = ctrl_q.sel;
    assign IMM_OUT       = ctrl_q.imm;
    assign WREN_OUT      = ctrl_q.wren;
    assign WRITE_AD_OUT  = ctrl_q.wad;
    assign ADR_MUX_OUT   = ctrl_q.adr_mux;
    assign WRITE_OUT     = ctrl_q.write;
    assign PC_LOAD_OUT   = ctrl_q.pc_load;
    assign ILLEGAL_OUT   = ctrl_q.illegal;

endmodule

// File: tb/tb_decode_control_unit.sv
// Self-checking bench for decode_control_unit: directed scenarios plus randomized
// traffic against a queue-based model of the emitted control-word stream.
module tb_decode_control_unit;

    logic        CLK = 1'b0;
    logic        RST;
    logic [15:0] INSTR_IN;
    logic        INSTR_VALID_IN;
    logic        INSTR_READY_OUT;
    logic        STALL_IN;
    logic        VALID_OUT, AR_OUT, BR_OUT;
    logic [3:0]  ALU_OUT;
    logic [1:0]  INPUT_SEL_OUT;
    logic [5:0]  IMM_OUT;
    logic        WREN_OUT;
    logic [2:0]  WRITE_AD_OUT;
    logic        ADR_MUX_OUT, WRITE_OUT, PC_LOAD_OUT, ILLEGAL_OUT;

    decode_control_unit #(.IW(16)) dut (
        .CLK(CLK), .RST(RST),
        .INSTR_IN(INSTR_IN), .INSTR_VALID_IN(INSTR_VALID_IN),
        .INSTR_READY_OUT(INSTR_READY_OUT), .STALL_IN(STALL_IN),
        .VALID_OUT(VALID_OUT), .AR_OUT(AR_OUT), .BR_OUT(BR_OUT),
        .ALU_OUT(ALU_OUT), .INPUT_SEL_OUT(INPUT_SEL_OUT), .IMM_OUT(IMM_OUT),
        .WREN_OUT(WREN_OUT), .WRITE_AD_OUT(WRITE_AD_OUT),
        .ADR_MUX_OUT(ADR_MUX_OUT), .WRITE_OUT(WRITE_OUT),
        .PC_LOAD_OUT(PC_LOAD_OUT), .ILLEGAL_OUT(ILLEGAL_OUT)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic       v;
        logic       ar;
        logic       br;
        logic [3:0] alu;
        logic [1:0] sel;
        logic [5:0] imm;
        logic       wren;
        logic [2:0] wad;
        logic       adr;
        logic       wr;
        logic       pcl;
        logic       ill;
    } w_t;

    w_t dut_w;
    assign dut_w = {VALID_OUT, AR_OUT, BR_OUT, ALU_OUT, INPUT_SEL_OUT, IMM_OUT,
                    WREN_OUT, WRITE_AD_OUT, ADR_MUX_OUT, WRITE_OUT, PC_LOAD_OUT, ILLEGAL_OUT};

    int total = 0;
    int bad   = 0;

    // Model: words still owed by the instruction in flight, plus the word on the outputs now.
    w_t pend[$];
    w_t m_out;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    // The words an instruction produces, in issue order (a jump owes one bubble).
    task automatic expand(input logic [15:0] i, output w_t s0, output w_t s1, output int n);
        logic [3:0] op;
        op = i[15:12];
        s0 = '0;
        s1 = '0;
        n  = 1;
        s0.v = 1'b1;
        if (op == 4'h0) begin
        end else if (op <= 4'h7) begin
            s0.ar = 1'b1; s0.br = 1'b1; s0.alu = op; s0.wren = 1'b1; s0.wad = i[11:9];
        end else if (op == 4'h8) begin
            s0.sel = 2'd1; s0.imm = i[5:0]; s0.wren = 1'b1; s0.wad = i[11:9];
        end else if (op == 4'h9) begin
            s0.ar = 1'b1; s0.adr = 1'b1;
            s1.v = 1'b1; s1.sel = 2'd2; s1.wren = 1'b1; s1.wad = i[11:9];
            n = 2;
        end else if (op == 4'hA) begin
            s0.ar = 1'b1; s0.br = 1'b1; s0.adr = 1'b1;
            s1.v = 1'b1; s1.wr = 1'b1;
            n = 2;
        end else if (op == 4'hB) begin
            s0.pcl = 1'b1; s0.imm = i[5:0];
            n = 2;
        end else begin
            s0.ill = 1'b1;
        end
    endtask

    function automatic bit raw(input w_t last, input logic [15:0] i);
`ifdef DECODE_HAZARD_EN
        logic [3:0] op;
        bit use_rd, use_rs;
        op = i[15:12];
        use_rd = (op >= 4'h1 && op <= 4'h7) || op == 4'hA;
        use_rs = (op >= 4'h1 && op <= 4'h7) || op == 4'h9 || op == 4'hA;
        return last.wren && ((use_rd && last.wad == i[11:9]) || (use_rs && last.wad == i[8:6]));
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        pend.delete();
        m_out = '0;
    endtask

    task automatic model_step();
        w_t s0, s1;
        int n;
        if (RST) begin
            model_reset();
        end else if (!STALL_IN) begin
            if (pend.size() != 0) begin
                m_out = pend.pop_front();
            end else if (INSTR_VALID_IN) begin
                expand(INSTR_IN, s0, s1, n);
                if (raw(m_out, INSTR_IN)) begin
                    pend.push_back(s0);
                    if (n == 2) pend.push_back(s1);
                    m_out = '0;
                end else begin
                    m_out = s0;
                    if (n == 2) pend.push_back(s1);
                end
            end else begin
                m_out = '0;
            end
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        model_step();
        #1;
    endtask

    always @(negedge CLK) begin
        chk("word", 32'(dut_w), 32'(m_out));
        chk("ready", 32'(INSTR_READY_OUT), 32'((pend.size() == 0) && !STALL_IN));
    end

    initial begin
        RST = 1'b1; INSTR_IN = '0; INSTR_VALID_IN = 1'b0; STALL_IN = 1'b0;
        model_reset();
        repeat (2) tick();
        RST = 1'b0;
        #1;
        chk("reset_word", 32'(dut_w), 32'd0);
        chk("reset_ready", 32'(INSTR_READY_OUT), 32'd1);

        // ALU rd=2 rs=3
        INSTR_IN = {4'h1, 3'd2, 3'd3, 6'd0}; INSTR_VALID_IN = 1'b1;
        tick(); INSTR_VALID_IN = 1'b0;
        chk("alu_valid", 32'(VALID_OUT), 32'd1);
        chk("alu_arbr", 32'({AR_OUT, BR_OUT}), 32'd3);
        chk("alu_op", 32'(ALU_OUT), 32'd1);
        chk("alu_wren", 32'(WREN_OUT), 32'd1);
        chk("alu_wad", 32'(WRITE_AD_OUT), 32'd2);
        tick();

        // LD rd=4 rs=1
        INSTR_IN = {4'h9, 3'd4, 3'd1, 6'd0}; INSTR_VALID_IN = 1'b1;
        tick(); INSTR_VALID_IN = 1'b0;
        chk("ldA_ar_adr", 32'({AR_OUT, ADR_MUX_OUT, WREN_OUT}), 32'b110);
        chk("ldA_ready", 32'(INSTR_READY_OUT), 32'd0);
        tick();
        chk("ldB_sel", 32'(INPUT_SEL_OUT), 32'd2);
        chk("ldB_wren_wad", 32'({WREN_OUT, WRITE_AD_OUT}), 32'b1100);
        chk("ldB_ready", 32'(INSTR_READY_OUT), 32'd1);

        // JMP imm=0x15 immediately followed by LDI rd=6 imm=7
        INSTR_IN = {4'hB, 3'd0, 3'd0, 6'h15}; INSTR_VALID_IN = 1'b1;
        tick();
        chk("jmp_pcl", 32'(PC_LOAD_OUT), 32'd1);
        chk("jmp_imm", 32'(IMM_OUT), 32'h15);
        chk("jmp_ready", 32'(INSTR_READY_OUT), 32'd0);
        INSTR_IN = {4'h8, 3'd6, 3'd0, 6'd7};
        tick();
        chk("flush_bubble", 32'(dut_w), 32'd0);
        chk("flush_ready", 32'(INSTR_READY_OUT), 32'd1);
        tick(); INSTR_VALID_IN = 1'b0;
        chk("ldi_after_flush", 32'({VALID_OUT, INPUT_SEL_OUT, IMM_OUT, WRITE_AD_OUT}),
            32'({1'b1, 2'd1, 6'd7, 3'd6}));
        tick();

        // LDI rd=5 then ALU(op 2) rd=1 rs=5
        INSTR_IN = {4'h8, 3'd5, 3'd0, 6'd1}; INSTR_VALID_IN = 1'b1;
        tick();
        chk("ldi5_wad", 32'(WRITE_AD_OUT), 32'd5);
        INSTR_IN = {4'h2, 3'd1, 3'd5, 6'd0};
        tick(); INSTR_VALID_IN = 1'b0;
`ifdef DECODE_HAZARD_EN
        chk("haz_bubble", 32'(VALID_OUT), 32'd0);
        chk("haz_ready", 32'(INSTR_READY_OUT), 32'd0);
        tick();
`endif
        chk("dep_alu", 32'({VALID_OUT, ALU_OUT, WRITE_AD_OUT}), 32'({1'b1, 4'd2, 3'd1}));
        tick();

        // undefined opcode 0xE
        INSTR_IN = {4'hE, 3'd3, 3'd3, 6'h3F}; INSTR_VALID_IN = 1'b1;
        tick(); INSTR_VALID_IN = 1'b0;
        chk("ill_word", 32'(dut_w), 32'({1'b1, 21'd0, 1'b1}));
        tick();
        chk("ill_pulse_end", 32'(ILLEGAL_OUT), 32'd0);

        // LD with stall during MEM2
        INSTR_IN = {4'h9, 3'd3, 3'd2, 6'd0}; INSTR_VALID_IN = 1'b1;
        tick();
        STALL_IN = 1'b1; INSTR_IN = {4'h1, 3'd0, 3'd0, 6'd0};
        for (int unsigned k = 0; k < 3; k++) begin
            tick();
            chk("stall_hold", 32'({AR_OUT, ADR_MUX_OUT, WREN_OUT, INSTR_READY_OUT}), 32'b1100);
        end
        STALL_IN = 1'b0; INSTR_VALID_IN = 1'b0;
        tick();
        chk("stall_ldB", 32'({INPUT_SEL_OUT, WREN_OUT, WRITE_AD_OUT}), 32'({2'd2, 1'b1, 3'd3}));

        // ST abandoned by reset during MEM2
        INSTR_IN = {4'hA, 3'd1, 3'd2, 6'd0}; INSTR_VALID_IN = 1'b1;
        tick(); INSTR_VALID_IN = 1'b0;
        chk("stA", 32'({AR_OUT, BR_OUT, ADR_MUX_OUT}), 32'b111);
        RST = 1'b1; model_reset();
        #1;
        chk("rst_mid_st", 32'(dut_w), 32'd0);
        tick();
        RST = 1'b0;
        for (int unsigned k = 0; k < 3; k++) begin
            tick();
            chk("no_write_after_rst", 32'({WRITE_OUT, WREN_OUT}), 32'd0);
        end

        // randomized traffic; small register range to provoke dependencies
        for (int unsigned k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 299) == 0) begin
                RST = 1'b1; model_reset();
                tick();
                RST = 1'b0;
            end
            STALL_IN       = ($urandom_range(0, 9) < 2);
            INSTR_VALID_IN = ($urandom_range(0, 9) < 7);
            INSTR_IN       = {4'($urandom_range(0, 15)), 3'($urandom_range(0, 2)),
                              3'($urandom_range(0, 2)), 6'($urandom_range(0, 63))};
            tick();
        end
        INSTR_VALID_IN = 1'b0; STALL_IN = 1'b0;
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decode_control_unit.md
# decode_control_unit

- Instruction decoder that produces the registered control bundle for the execute stage.
- Accepts one 16-bit instruction per valid/ready handshake and emits, one cycle later, the register-load, ALU, input-select, write-address, address-mux, memory-write and PC-load controls.
- Sequences two-cycle memory instructions, flushes after jumps, and optionally interlocks read-after-write hazards.
- Sits between instruction fetch and the decode/execute pipeline register.

## Interface
Parameters:
- IW, 16, instruction width (fixed format below; other values unsupported)

Ports:
- CLK  in  1  clock; all state updates on posedge
- RST  in  1  asynchronous, active-high reset
- INSTR_IN  in  16  instruction: [15:12] opcode, [11:9] rd, [8:6] rs, [5:0] imm
- INSTR_VALID_IN  in  1  fetch offers INSTR_IN
- INSTR_READY_OUT  out  1  decoder accepts this cycle
- STALL_IN  in  1  downstream cannot take a new control word
- VALID_OUT  out  1  control outputs carry a real operation
- AR_OUT  out  1  load A operand register
- BR_OUT  out  1  load B operand register
- ALU_OUT  out  4  ALU operation code
- INPUT_SEL_OUT  out  2  writeback source: 0 ALU, 1 immediate, 2 memory
- IMM_OUT  out  6  immediate field
- WREN_OUT  out  1  register-file write enable
- WRITE_AD_OUT  out  3  register-file write address
- ADR_MUX_OUT  out  1  memory address source: 0 PC, 1 register
- WRITE_OUT  out  1  memory write strobe
- PC_LOAD_OUT  out  1  load PC from jump target
- ILLEGAL_OUT  out  1  one-cycle pulse on an undefined opcode

## Operation
- Transfer occurs when INSTR_VALID_IN && INSTR_READY_OUT. INSTR_READY_OUT = (state==RUN) && !STALL_IN, combinational.
- Opcode 0x0 NOP: VALID_OUT=1, all controls 0.
- Opcodes 0x1–0x7 ALU: AR_OUT=1, BR_OUT=1, ALU_OUT=opcode, INPUT_SEL=0, WREN=1, WRITE_AD=rd. Sources are rd and rs.
- Opcode 0x8 LDI: INPUT_SEL=1, IMM_OUT=imm, WREN=1, WRITE_AD=rd. No sources.
- Opcode 0x9 LD:
  - Cycle A: AR_OUT=1, ADR_MUX=1. Source is rs.
  - Cycle B (state MEM2): INPUT_SEL=2, WREN=1, WRITE_AD=rd.
- Opcode 0xA ST:
  - Cycle A: AR_OUT=1, BR_OUT=1, ADR_MUX=1. Sources are rs and rd.
  - Cycle B (state MEM2): WRITE_OUT=1.
- Opcode 0xB JMP: PC_LOAD=1, IMM_OUT=imm, then state FLUSH for one cycle.
- Opcodes 0xC–0xF: emit a NOP word with VALID_OUT=1 and ILLEGAL_OUT=1.
- States: RUN, MEM2, FLUSH, HAZ.
  - RUN: on accept, go to MEM2 for LD/ST, FLUSH for JMP, HAZ on hazard, else stay in RUN.
  - MEM2 → RUN.
  - FLUSH → RUN; outputs a bubble (VALID_OUT=0, all controls 0).
  - HAZ: issues the held instruction, then follows the RUN rules for that opcode.
- Hazard: the previous issued word had WREN=1 and its WRITE_AD equals a source of the accepted instruction.
  - Emit one bubble, hold the instruction, enter HAZ.
  - A held LD/ST then proceeds to MEM2.
- No transfer in RUN: emit a bubble.

## Timing
- All outputs registered except INSTR_READY_OUT. Latency from accept to control word: 1 cycle; 2 cycles when a hazard bubble is inserted.
- STALL_IN high: state and all registered outputs hold their values; no accept. The hazard comparison uses the last issued word, not a bubble.
- A bubble clears the hazard tracking, so two bubbles are never inserted back-to-back.
- Reset values: VALID_OUT, all controls, IMM_OUT and ILLEGAL_OUT = 0; state=RUN; held instruction = 0; hazard tracking cleared.
- RST asserted mid-LD/ST or mid-FLUSH abandons the sequence; no WRITE_OUT or WREN pulse is emitted afterwards.
- Instruction throughput:
  - 1 per cycle for NOP, ALU, LDI and illegal opcodes.
  - 1 per 2 cycles for LD, ST and JMP.

## Configuration
- DECODE_HAZARD_EN defined: RAW interlock and the HAZ state are present as described above.
- DECODE_HAZARD_EN undefined:
  - No hazard comparison and HAZ is unreachable.
  - Dependent instructions issue back-to-back.
  - The forwarding path is then responsible for correctness.

## Test plan
- Reset, then ALU 0x1 with rd=2, rs=3, valid for one cycle → next cycle VALID_OUT=1, AR=BR=1, ALU_OUT=1, WREN=1, WRITE_AD=2.
- LD with rd=4, rs=1 → cycle A: AR=1, ADR_MUX=1, READY low. Cycle B: INPUT_SEL=2, WREN=1, WRITE_AD=4. READY high again after cycle B.
- JMP with imm=0x15, followed immediately by a valid instruction → PC_LOAD=1, IMM_OUT=0x15. The next cycle is a bubble and the following instruction is accepted only after FLUSH.
- With DECODE_HAZARD_EN: LDI rd=5, then ALU rs=5 → LDI word, then one bubble, then the ALU word. Without the macro: no bubble.
- Opcode 0xE → VALID_OUT=1, ILLEGAL_OUT pulses for exactly one cycle, all controls 0.
- STALL_IN held for 3 cycles during MEM2 → cycle-A outputs hold and no accept occurs. Assert RST during MEM2 → all outputs 0 and WRITE_OUT never asserts.
